// File: rtl/usb_data_tx_seq.sv
// ---------------------------------------------------------------------------
// usb_data_tx_seq
//   Builds USB DATA packets (PID byte, payload, CRC16) for the transmit path.
//   Payload bytes come in on a valid/ready stream. The packet byte stream goes
//   out through a single registered slot towards the NRZI/bit-stuff serializer.
//   An internal usb_crc16_8 engine is cleared once per packet and fed each
//   payload byte. The inverted CRC is appended low byte first.
//   Payload underrun and over-length both abort the packet with a marker byte.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle packet request, sampled only in IDLE
//   pid[3:0], zlp   PID nibble and zero-length flag, latched on accepted start
//   in_data[7:0], in_valid, in_last, in_ready
//                   payload stream (byte accepted when in_valid & in_ready)
//   out_data[7:0], out_valid, out_last, out_abort, out_ready
//                   packet byte stream (byte taken when out_valid & out_ready)
//   busy            high from accepted start until return to IDLE
//   done            one-cycle pulse after the CRC high byte is taken
//   err_underrun    one-cycle pulse when a starved payload aborts the packet
//   err_overlong    one-cycle pulse when an over-length payload aborts it
// ---------------------------------------------------------------------------

// usb_crc16_8: byte-wide USB CRC16 (x^16+x^15+x^2+1, LSB-first, preset FFFF).
//   clk, rst_n      clock; rst_n low presets the register to FFFF
//   data_valid      fold data[7:0] into the CRC on this edge
//   crc[15:0]       current (non-inverted) CRC register
module usb_crc16_8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // One byte of the reflected CRC16, bit 0 of the byte first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                             input logic [7:0]  d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ d[i]) == 1'b1) begin
        r = (r >> 1) ^ 16'hA001;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

  logic [15:0] crc_d;
  logic [15:0] crc_q;

  // Next CRC value: fold in the byte only when it is presented.
  always_comb begin
    crc_d = crc_q;
    if (data_valid) begin
      crc_d = crc16_byte(crc_q, data);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register, preset to all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

module usb_data_tx_seq #(
  parameter int MAX_PAYLOAD     = 64,
  parameter int UNDERRUN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic       zlp,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       out_abort,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       err_underrun,
  output logic       err_overlong
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
  localparam int STV_W = $clog2(UNDERRUN_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(UNDERRUN_CYCLES - 1);
  localparam logic [STV_W-1:0] STV_ONE   = STV_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PID     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CRC_LO  = 3'd3;
  localparam logic [2:0] S_CRC_HI  = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_ABORT   = 3'd6;

  logic [2:0]       state_q,     state_d;
  logic [3:0]       pid_q,       pid_d;
  logic             zlp_q,       zlp_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [STV_W-1:0] stv_q,       stv_d;
  logic             crc_clr_q,   crc_clr_d;
  logic [7:0]       out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             out_abort_q, out_abort_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             err_un_q,    err_un_d;
  logic             err_ov_q,    err_ov_d;

  logic        slot_empty;
  logic        slot_taken;
  logic        accept;
  logic        crc_feed;
  logic        crc_rst_n;
  logic [15:0] crc_result;

  // The slot can take a new byte when it is empty or being handed off now.
  assign slot_taken = out_valid_q & out_ready;
  assign slot_empty = ~out_valid_q | out_ready;
  assign in_ready   = (state_q == S_PAYLOAD) & slot_empty;
  assign accept     = in_valid & in_ready;

  // The engine is preset by a flop, never by a decoded state, so its async
  // clear cannot glitch.
  assign crc_rst_n = rst_n & ~crc_clr_q;

  usb_crc16_8 u_crc (
    .clk        (clk),
    .rst_n      (crc_rst_n),
    .data_valid (crc_feed),
    .data       (in_data),
    .crc        (crc_result)
  );

  // Packet sequencer: next state, output slot loading and status pulses.
  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    zlp_d     = zlp_q;
    cnt_d     = cnt_q;
    stv_d     = stv_q;
    crc_clr_d = 1'b0;
    crc_feed  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_un_d  = 1'b0;
    err_ov_d  = 1'b0;

    // A handed-off slot empties and goes back to all zeros unless reloaded.
    if (slot_taken) begin
      out_valid_d = 1'b0;
      out_data_d  = 8'h00;
      out_last_d  = 1'b0;
      out_abort_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_abort_d = out_abort_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pid_d     = pid;
          zlp_d     = zlp;
          cnt_d     = {CNT_W{1'b0}};
          stv_d     = {STV_W{1'b0}};
          crc_clr_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_PID;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PID: begin
        if (slot_empty) begin
          out_valid_d = 1'b1;
          out_data_d  = {~pid_q, pid_q};
          out_last_d  = 1'b0;
          out_abort_d = 1'b0;
          state_d     = zlp_q ? S_CRC_LO : S_PAYLOAD;
        end else begin
          state_d = S_PID;
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          stv_d = {STV_W{1'b0}};
          if (cnt_q == CNT_MAX) begin
            // One byte too many: drop it and terminate the packet.
            err_ov_d = 1'b1;
            state_d  = S_ABORT;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_last_d  = 1'b0;
            out_abort_d = 1'b0;
            crc_feed    = 1'b1;
            cnt_d       = cnt_q + CNT_ONE;
            state_d     = in_last ? S_CRC_LO : S_PAYLOAD;
          end
        end else if (slot_empty && !in_valid) begin
          // Starved while able to send: count towards an underrun.
          stv_d = stv_q + STV_ONE;
          if (stv_q == STV_LIMIT) begin
            err_un_d = 1'b1;
            state_d  = S_ABORT;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end

      S_CRC_LO: begin
        // The engine already holds the final value: it updated on the edge
        // that accepted the last payload byte.
        if (slot_empty) begin
          out_valid_d = 1'b1;
          out_data_d  = ~crc_result[7:0];
          out_last_d  = 1'b0;
          out_abort_d = 1'b0;
          state_d     = S_CRC_HI;
        end else begin
          state_d = S_CRC_LO;
        end
      end

      S_CRC_HI: begin
        if (slot_empty) begin
          out_valid_d = 1'b1;
          out_data_d  = ~crc_result[15:8];
          out_last_d  = 1'b1;
          out_abort_d = 1'b0;
          state_d     = S_DRAIN;
        end else begin
          state_d = S_CRC_HI;
        end
      end

      S_ABORT: begin
        if (slot_empty) begin
          out_valid_d = 1'b1;
          out_data_d  = 8'h00;
          out_last_d  = 1'b1;
          out_abort_d = 1'b1;
          state_d     = S_DRAIN;
        end else begin
          state_d = S_ABORT;
        end
      end

      S_DRAIN: begin
        // The slot holds the final byte (CRC high or abort marker). Only a
        // normal ending reports done.
        if (slot_taken) begin
          done_d  = ~out_abort_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        out_last_d  = 1'b0;
        out_abort_d = 1'b0;
      end
    endcase
  end

  // State, output slot and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pid_q       <= 4'h0;
      zlp_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      stv_q       <= {STV_W{1'b0}};
      crc_clr_q   <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_abort_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_un_q    <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      zlp_q       <= zlp_d;
      cnt_q       <= cnt_d;
      stv_q       <= stv_d;
      crc_clr_q   <= crc_clr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_abort_q <= out_abort_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_un_q    <= err_un_d;
      err_ov_q    <= err_ov_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_abort    = out_abort_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_underrun = err_un_q;
  assign err_overlong = err_ov_q;

endmodule

// File: tb/tb_usb_data_tx_seq.sv
// ---------------------------------------------------------------------------
// tb_usb_data_tx_seq
//   Self-checking bench for usb_data_tx_seq. A feeder process plays queued
//   payload bytes (with per-byte idle gaps) and drives out_ready. A monitor
//   captures every handed-off output byte. Expected packets come from a
//   reference model: the PID byte, the payload, and either an abort marker or
//   the inverted USB CRC16. The CRC is computed in the MSB-first form of the
//   polynomial, with bit reversal.
// ---------------------------------------------------------------------------
module tb_usb_data_tx_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pid = 4'h0;
  logic       zlp = 1'b0;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_abort;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       err_underrun;
  logic       err_overlong;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usb_data_tx_seq #(.MAX_PAYLOAD(64), .UNDERRUN_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pid          (pid),
    .zlp          (zlp),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_abort    (out_abort),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun),
    .err_overlong (err_overlong)
  );

  // Source queues, output capture and event bookkeeping.
  logic [7:0] src_data[$];
  logic       src_last[$];
  int         src_gap[$];
  int         ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
  logic [9:0] cap_q[$];         // {abort, last, data}
  logic [9:0] exp_q[$];
  logic [7:0] pay [0:127];
  int cyc = 0;
  int start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  int done_cnt, un_cnt, ov_cnt, stab_err, acc_cnt;
  bit timed_out;
  bit         prev_stall = 1'b0;
  logic [9:0] prev_slot = 10'h000;

  always @(posedge clk) cyc <= cyc + 1;

  // Feeder: pops accepted bytes, applies gaps, drives out_ready.
  initial begin : feeder
    bit acc_l;
    bit tog;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1; tog = 1'b0;
    forever begin
      @(negedge clk);
      acc_l = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc_l && src_data.size() > 0) begin
        void'(src_data.pop_front());
        void'(src_last.pop_front());
        void'(src_gap.pop_front());
      end
      if (src_data.size() > 0 && src_gap[0] > 0) begin
        src_gap[0] = src_gap[0] - 1;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      end else if (src_data.size() > 0) begin
        in_valid = 1'b1; in_data = src_data[0]; in_last = src_last[0];
      end else begin
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin tog = ~tog; out_ready = tog; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: capture handshakes, pulses, and slot stability while stalled.
  always @(negedge clk) begin
    if (rst_n && prev_stall && (!out_valid || {out_abort, out_last, out_data} != prev_slot))
      stab_err++;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_slot  = {out_abort, out_last, out_data};
    if (out_valid && out_ready) begin
      cap_q.push_back({out_abort, out_last, out_data});
      if (out_last) last_hs_cyc = cyc;
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (in_valid && in_ready) acc_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err_underrun) un_cnt++;
    if (err_overlong) ov_cnt++;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference USB CRC16 of pay[0..n-1]: MSB-first shift register, reflected at the end.
  function automatic logic [15:0] usb_crc16(input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[15] ^ pay[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int b = 0; b < 16; b++) r[b] = c[15-b];
    return r;
  endfunction

  task automatic build_expected(input logic [3:0] p, input int nsent, input bit aborted);
    logic [15:0] r;
    exp_q.delete();
    exp_q.push_back({2'b00, ~p, p});
    for (int i = 0; i < nsent; i++) exp_q.push_back({2'b00, pay[i]});
    if (aborted) begin
      exp_q.push_back(10'b11_0000_0000);
    end else begin
      r = usb_crc16(nsent);
      exp_q.push_back({2'b00, ~r[7:0]});
      exp_q.push_back({2'b01, ~r[15:8]});
    end
  endtask

  task automatic load_src(input int n, input bit with_last, input int gap_idx,
                          input int gap_len, input bit rand_gap);
    for (int i = 0; i < n; i++) begin
      src_data.push_back(pay[i]);
      src_last.push_back(with_last && (i == n - 1));
      if (rand_gap) src_gap.push_back(int'($urandom_range(0, 2)));
      else          src_gap.push_back((i == gap_idx) ? gap_len : 0);
    end
  endtask

  task automatic flush_src();
    src_data.delete(); src_last.delete(); src_gap.delete();
  endtask

  task automatic clear_mon();
    cap_q.delete();
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    done_cnt = 0; un_cnt = 0; ov_cnt = 0; stab_err = 0; acc_cnt = 0;
  endtask

  task automatic run_packet(input logic [3:0] p, input bit z, input int budget);
    clear_mon();
    @(posedge clk); #2;
    start = 1'b1; pid = p; zlp = z; start_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0; zlp = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin timed_out = 1'b0; break; end
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, out_abort, busy, done, err_underrun, err_overlong, in_ready} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 00000000",
               {out_valid, out_last, out_abort, busy, done, err_underrun, err_overlong, in_ready});
    end
    n_cmp++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", out_data); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_zlp();
    run_packet(4'h3, 1'b1, 200);
    build_expected(4'h3, 0, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL zlp_timeout: busy still %b, expected 0", busy); end
    n_cmp++;
    if (cap_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL zlp_len: got %0d bytes, expected %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zlp_byte%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
    end
    n_cmp++; if (first_valid_cyc - start_cyc !== 2) begin n_fail++; $display("FAIL zlp_latency: got %0d, expected 2", first_valid_cyc - start_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zlp_done_cnt: got %0d, expected 1", done_cnt); end
    n_cmp++; if (done_cyc !== last_hs_cyc + 1) begin n_fail++; $display("FAIL zlp_done_timing: got %0d, expected %0d", done_cyc, last_hs_cyc + 1); end
  endtask

  task automatic test_data1(input int rmode, input string nm);
    ready_mode = rmode;
    for (int i = 0; i < 4; i++) pay[i] = 8'(i);
    load_src(4, 1'b1, -1, 0, 1'b0);
    run_packet(4'hB, 1'b0, 300);
    build_expected(4'hB, 4, 1'b0);
    ready_mode = 0;
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL %s_timeout: busy still %b, expected 0", nm, busy); end
    n_cmp++;
    if (cap_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL %s_len: got %0d bytes, expected %0d", nm, cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_byte%0d: got %h, expected %h", nm, i, cap_q[i], exp_q[i]); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d, expected 1", nm, done_cnt); end
    n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL %s_stall_stable: got %0d changes, expected 0", nm, stab_err); end
  endtask

  task automatic test_max_payload();
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom_range(0, 255));
    load_src(64, 1'b1, -1, 0, 1'b0);
    run_packet(4'h3, 1'b0, 400);
    build_expected(4'h3, 64, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL max_timeout: busy still %b, expected 0", busy); end
    n_cmp++;
    if (cap_q.size() !== 67) begin n_fail++; $display("FAIL max_len: got %0d bytes, expected 67", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL max_byte%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
    end
    n_cmp++; if (done_cnt !== 1 || ov_cnt !== 0) begin n_fail++; $display("FAIL max_status: got done=%0d ovl=%0d, expected 1 0", done_cnt, ov_cnt); end
  endtask

  task automatic test_overlong();
    for (int i = 0; i < 65; i++) pay[i] = 8'($urandom_range(0, 255));
    load_src(65, 1'b0, -1, 0, 1'b0);
    run_packet(4'hB, 1'b0, 400);
    flush_src();
    build_expected(4'hB, 64, 1'b1);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL ovl_timeout: busy still %b, expected 0", busy); end
    n_cmp++;
    if (cap_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovl_len: got %0d bytes, expected %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovl_byte%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
    end
    n_cmp++; if (ov_cnt !== 1) begin n_fail++; $display("FAIL ovl_err: got %0d pulses, expected 1", ov_cnt); end
    n_cmp++; if (done_cnt !== 0 || un_cnt !== 0) begin n_fail++; $display("FAIL ovl_status: got done=%0d und=%0d, expected 0 0", done_cnt, un_cnt); end
  endtask

  task automatic test_underrun(input int gap, input string nm);
    bit expect_err;
    expect_err = (gap >= 4);
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom_range(0, 255));
    load_src(6, 1'b1, 2, gap, 1'b0);
    run_packet(4'h3, 1'b0, 300);
    flush_src();
    if (expect_err) build_expected(4'h3, 2, 1'b1);
    else            build_expected(4'h3, 6, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL %s_timeout: busy still %b, expected 0", nm, busy); end
    n_cmp++;
    if (cap_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL %s_len: got %0d bytes, expected %0d", nm, cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_byte%0d: got %h, expected %h", nm, i, cap_q[i], exp_q[i]); end
    end
    n_cmp++; if (un_cnt !== (expect_err ? 1 : 0)) begin n_fail++; $display("FAIL %s_err: got %0d pulses, expected %0d", nm, un_cnt, expect_err ? 1 : 0); end
    n_cmp++; if (done_cnt !== (expect_err ? 0 : 1)) begin n_fail++; $display("FAIL %s_done: got %0d, expected %0d", nm, done_cnt, expect_err ? 0 : 1); end
  endtask

  task automatic test_reset_mid_packet();
    bit hit;
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom_range(0, 255));
    load_src(20, 1'b1, -1, 0, 1'b0);
    clear_mon();
    @(posedge clk); #2;
    start = 1'b1; pid = 4'h3;
    @(posedge clk); #2;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (acc_cnt >= 10) begin hit = 1'b1; break; end
      @(posedge clk); #2;
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach: got %0d bytes accepted, expected 10", acc_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, out_abort, busy, done, err_underrun, err_overlong, in_ready, out_data} !== 16'h0000) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h, expected 0000",
               {out_valid, out_last, out_abort, busy, done, err_underrun, err_overlong, in_ready, out_data});
    end
    flush_src();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 12; i++) pay[i] = 8'($urandom_range(0, 255));
    load_src(12, 1'b1, -1, 0, 1'b0);
    run_packet(4'hB, 1'b0, 300);
    build_expected(4'hB, 12, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rstmid_timeout: busy still %b, expected 0", busy); end
    n_cmp++;
    if (cap_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_len: got %0d bytes, expected %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rstmid_done: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] p;
    int len;
    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 3))
        0:       p = 4'h3;
        1:       p = 4'hB;
        2:       p = 4'h7;
        default: p = 4'hF;
      endcase
      len = int'($urandom_range(0, 64));
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom_range(0, 255));
      load_src(len, 1'b1, -1, 0, 1'b1);
      run_packet(p, (len == 0), 2000);
      flush_src();
      build_expected(p, len, 1'b0);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rnd%0d_timeout: busy still %b, expected 0", t, busy); end
      n_cmp++;
      if (cap_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_len: got %0d bytes, expected %0d", t, cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        n_cmp++;
        if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h, expected %h", t, i, cap_q[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt !== 1 || stab_err !== 0) begin n_fail++; $display("FAIL rnd%0d_status: got done=%0d stall_changes=%0d, expected 1 0", t, done_cnt, stab_err); end
    end
    ready_mode = 0;
    @(posedge clk); #2;
  endtask

  initial begin : main
    clear_mon();
    test_reset();
    test_zlp();
    test_data1(0, "data1");
    test_data1(1, "stall");
    test_max_payload();
    test_overlong();
    test_underrun(4, "under4");
    test_underrun(3, "under3");
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
